// File: rtl/y_mdu.sv
// y_mdu: iterative multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per clock, with a
// start/busy/done handshake. The signed variants (MULH, DIV, REM) are only
// built when the macro Y_MDU_SIGNED_EN is defined; otherwise op[2] is ignored.
module y_mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  // hi: product high half (multiply) or partial remainder (divide)
  // lo: multiplier being shifted out (multiply) or dividend/quotient (divide)
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  opb;
  logic [1:0]        op_r;

  logic [WIDTH-1:0]  a_m;
  logic [WIDTH-1:0]  b_m;

  logic [WIDTH:0]    add_sum;
  logic [WIDTH-1:0]  mhi_n;
  logic [WIDTH-1:0]  mlo_n;
  logic [WIDTH:0]    shifted;
  logic [WIDTH-1:0]  trial;
  logic [WIDTH-1:0]  drem_n;
  logic [WIDTH-1:0]  dq_n;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   rdz;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   res_dz;
  logic               div0;

`ifdef Y_MDU_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    mag = (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] fix_word(input logic [WIDTH-1:0] v, input logic neg);
    fix_word = neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_prod(input logic [2*WIDTH-1:0] v, input logic neg);
    fix_prod = neg ? -v : v;
  endfunction

  // Signed ops run on magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  always_comb begin
    a_m = mag(a, op[2]);
    b_m = mag(b, op[2]);
  end
`else
  logic unused_sign;
  assign unused_sign = op[2];

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    a_m = a;
    b_m = b;
  end
`endif

  // One multiply step and one restoring-divide step, evaluated every cycle.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    mhi_n   = add_sum[WIDTH:1];
    mlo_n   = {add_sum[0], lo[WIDTH-1:1]};
    shifted = {hi, lo[WIDTH-1]};
    // When shifted >= divisor the true difference is below the divisor,
    // so the WIDTH-bit wrap-around subtraction is exact.
    trial   = shifted[WIDTH-1:0] - opb;
    if (shifted >= {1'b0, opb}) begin
      drem_n = trial;
      dq_n   = {lo[WIDTH-2:0], 1'b1};
    end else begin
      drem_n = shifted[WIDTH-1:0];
      dq_n   = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection, including sign fix-up on the edge entering DONE.
  always_comb begin
    prod = {mhi_n, mlo_n};
    quo  = dq_n;
    rmd  = drem_n;
    rdz  = lo;
`ifdef Y_MDU_SIGNED_EN
    prod = fix_prod(prod, neg_q);
    quo  = fix_word(quo, neg_q);
    rmd  = fix_word(rmd, neg_r);
    rdz  = fix_word(rdz, neg_r);
`endif
    case (op_r)
      2'b00:   res = prod[WIDTH-1:0];
      2'b01:   res = prod[2*WIDTH-1:WIDTH];
      2'b10:   res = quo;
      default: res = rmd;
    endcase
    res_dz = op_r[0] ? rdz : '1;
    div0   = op_r[1] && (opb == '0);
  end

  // Control FSM and datapath registers; z only moves on entry to DONE or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      op_r  <= '0;
`ifdef Y_MDU_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            hi    <= '0;
            lo    <= op[1] ? a_m : b_m;
            opb   <= op[1] ? b_m : a_m;
            op_r  <= op[1:0];
`ifdef Y_MDU_SIGNED_EN
            neg_q <= op[2] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= op[2] & a[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (div0) begin
            z     <= res_dz;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            hi  <= op_r[1] ? drem_n : mhi_n;
            lo  <= op_r[1] ? dq_n   : mlo_n;
            if (cnt == LAST) begin
              z     <= res;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_mdu.sv
// tb_y_mdu: directed testbench for y_mdu (WIDTH=32). Signed cases are
// included only when Y_MDU_SIGNED_EN is defined.
module tb_y_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z;

  int n_vec;
  int n_err;

  y_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .kill  (kill),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for exactly one edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      step();
      lat++;
      if (busy && !done) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    step();
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 32'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b z=%h, required 0 0 00000000", busy, done, z);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int lat, bcnt;
    issue(3'b000, 32'd7, 32'd6);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mul_busy_after_start: busy=%b, required 1", busy);
    end
    wait_done(lat, bcnt);
    n_vec++;
    if (lat !== 32) begin
      n_err++;
      $display("FAIL mul_latency: got %0d edges, required 32", lat);
    end
    n_vec++;
    if (bcnt !== 32) begin
      n_err++;
      $display("FAIL mul_busy_cycles: got %0d, required 32", bcnt);
    end
    n_vec++;
    if (z !== 32'd42 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mul_result: z=%0d busy=%b, required z=42 busy=0", z, busy);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || z !== 32'd42) begin
      n_err++;
      $display("FAIL mul_done_pulse: done=%b busy=%b z=%0d, required 0 0 42", done, busy, z);
    end
  endtask

  task automatic test_mulhu();
    int lat, bcnt;
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'hFFFF_FFFE || lat !== 32) begin
      n_err++;
      $display("FAIL mulhu_max: z=%h lat=%0d, required fffffffe 32", z, lat);
    end
    step();
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL mul_max_low: z=%h, required 00000001", z);
    end
    step();
    issue(3'b001, 32'h0001_0000, 32'h0003_0000);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL mulhu_shift: z=%h, required 00000003", z);
    end
    step();
    issue(3'b000, 32'h1234_5678, 32'h0);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'h0 || lat !== 32) begin
      n_err++;
      $display("FAIL mul_by_zero: z=%h lat=%0d, required 00000000 32", z, lat);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    issue(3'b010, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd14 || lat !== 32) begin
      n_err++;
      $display("FAIL divu_100_7: z=%0d lat=%0d, required 14 32", z, lat);
    end
    // New request in the DONE cycle of the previous one.
    issue(3'b011, 32'd100, 32'd7);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || z !== 32'd14) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b z=%0d, required 1 0 14", busy, done, z);
    end
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd2 || lat !== 32) begin
      n_err++;
      $display("FAIL remu_100_7: z=%0d lat=%0d, required 2 32", z, lat);
    end
    step();
    issue(3'b010, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL divu_max_1: z=%h, required ffffffff", z);
    end
    step();
    issue(3'b011, 32'd7, 32'd100);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd7) begin
      n_err++;
      $display("FAIL remu_small: z=%0d, required 7", z);
    end
    step();
    issue(3'b010, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd1) begin
      n_err++;
      $display("FAIL divu_msb_divisor: z=%h, required 00000001", z);
    end
    step();
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    issue(3'b010, 32'd55, 32'd0);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'hFFFF_FFFF || lat !== 1) begin
      n_err++;
      $display("FAIL divu_by_zero: z=%h lat=%0d, required ffffffff 1", z, lat);
    end
    step();
    issue(3'b011, 32'd55, 32'd0);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd55 || lat !== 1) begin
      n_err++;
      $display("FAIL remu_by_zero: z=%0d lat=%0d, required 55 1", z, lat);
    end
    step();
  endtask

  task automatic test_kill();
    int lat, bcnt, dcnt;
    issue(3'b000, 32'd9, 32'd9);
    for (int i = 0; i < 9; i++) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 32'd55) begin
      n_err++;
      $display("FAIL kill_abort: busy=%b done=%b z=%0d, required 0 0 55", busy, done, z);
    end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dcnt++;
    end
    n_vec++;
    if (dcnt !== 0 || z !== 32'd55) begin
      n_err++;
      $display("FAIL kill_no_done: done pulses=%0d z=%0d, required 0 55", dcnt, z);
    end
    // start and kill together while idle: start wins
    kill = 1'b1;
    issue(3'b000, 32'd3, 32'd5);
    kill = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_beats_kill: busy=%b, required 1", busy);
    end
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd15 || lat !== 32) begin
      n_err++;
      $display("FAIL start_beats_kill_result: z=%0d lat=%0d, required 15 32", z, lat);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int lat, bcnt;
    issue(3'b000, 32'd7, 32'd6);
    for (int i = 0; i < 5; i++) step();
    op    = 3'b010;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    start = 1'b0;
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd42 || lat + 8 !== 32) begin
      n_err++;
      $display("FAIL start_ignored_busy: z=%0d total_lat=%0d, required 42 32", z, lat + 8);
    end
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL no_queued_start: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt;
    issue(3'b000, 32'd11, 32'd11);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    start = 1'b1;
    kill  = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_run: busy=%b done=%b z=%h, required 0 0 00000000", busy, done, z);
    end
    rst_n = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    step();
    issue(3'b000, 32'd3, 32'd4);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'd12 || lat !== 32) begin
      n_err++;
      $display("FAIL after_reset_mul: z=%0d lat=%0d, required 12 32", z, lat);
    end
    step();
  endtask

`ifdef Y_MDU_SIGNED_EN
  task automatic test_signed();
    int lat, bcnt;
    issue(3'b110, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL div_neg7_2: z=%h, required fffffffd", z);
    end
    step();
    issue(3'b111, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL rem_neg7_2: z=%h, required ffffffff", z);
    end
    step();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'h8000_0000 || lat !== 32) begin
      n_err++;
      $display("FAIL div_overflow: z=%h lat=%0d, required 80000000 32", z, lat);
    end
    step();
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    n_vec++;
    if (z !== 32'h0) begin
      n_err++;
      $display("FAIL mulh_neg1: z=%h, required 00000000", z);
    end
    step();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mul();
    test_mulhu();
    test_back_to_back();
    test_div_zero();
    test_kill();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef Y_MDU_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
